// File: rtl/ram_word_display_if.sv
// rtl/ram_word_display_if.sv - word-select read port between the viewer and the data RAM
interface ram_word_display_if;
  logic [3:0]  mem_choose;
  logic [31:0] chosen_data;

  // Viewer side: drives the word select, receives the combinational read data
  modport master (output mem_choose, input chosen_data);

  // RAM side: observes the word select, returns the selected word
  modport slave (input mem_choose, output chosen_data);
endinterface

// File: rtl/ram_word_display.sv
// rtl/ram_word_display.sv - debounced address stepping and 8-digit hex viewer for a RAM word
module ram_word_display #(
  parameter int SCAN_DIV   = 100000,
  parameter int DEB_CYCLES = 200000,
  parameter int AUTO_DIV   = 50000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  btn_inc,
  input  logic                  btn_dec,
  input  logic                  auto_en,
  input  logic                  freeze,
  ram_word_display_if.master    ram,
  output logic [7:0]            an,
  output logic [6:0]            seg
);

  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;
  localparam int SW = $clog2(SCAN_DIV);
  localparam int AW = $clog2(AUTO_DIV);

  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_DIV - 1);

  // Index 0 is the increment button, index 1 the decrement button
  logic [1:0]         btn_raw;
  logic [1:0]         sync1;
  logic [1:0]         sync2;
  logic [1:0]         deb_lvl;
  logic [1:0][DW-1:0] deb_cnt;
  logic [1:0]         flip_up;
  logic [1:0]         armed;
  logic [1:0]         press;
  logic [1:0]         settle_cnt;
  logic               settled;

  logic [AW-1:0]      auto_cnt;
  logic               tick;
  logic               step_up;
  logic               step_dn;

  logic [3:0]         addr;
  logic [31:0]        word;
  logic [SW-1:0]      scan_cnt;
  logic [2:0]         digit;
  logic [3:0]         nibble;

  assign btn_raw = {btn_dec, btn_inc};

  // Two-flop synchronisers for both raw buttons
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 2'b00;
      sync2 <= 2'b00;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  // Counts the two edges after reset until sync2 reflects the real button level
  always_ff @(posedge clk) begin
    if (rst) begin
      settle_cnt <= 2'd0;
    end else if (!settled) begin
      settle_cnt <= settle_cnt + 2'd1;
    end
  end

  assign settled = (settle_cnt == 2'd2);

  // Debounce: count while synced level disagrees, flip the accepted level on reaching the limit
  always_ff @(posedge clk) begin
    if (rst) begin
      deb_lvl <= 2'b00;
      deb_cnt <= '0;
      armed   <= 2'b00;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] != deb_lvl[i]) begin
          if (deb_cnt[i] == DEB_LAST) begin
            deb_lvl[i] <= sync2[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + 1'b1;
          end
        end else begin
          deb_cnt[i] <= '0;
        end
        // A button only becomes live once it has been seen released after reset,
        // so a press held through reset never yields an event.
        if (settled && !sync2[i]) begin
          armed[i] <= 1'b1;
        end
      end
    end
  end

  // Press pulse is the cycle in which the accepted level is about to go 0->1
  always_comb begin
    flip_up = 2'b00;
    press   = 2'b00;
    for (int i = 0; i < 2; i++) begin
      flip_up[i] = sync2[i] && !deb_lvl[i] && (deb_cnt[i] == DEB_LAST);
      press[i]   = flip_up[i] && armed[i];
    end
  end

  assign tick = auto_en && (auto_cnt == AUTO_LAST);

  // Auto-advance divider; held at zero when disabled and restarted by any press
  always_ff @(posedge clk) begin
    if (rst) begin
      auto_cnt <= '0;
    end else if (!auto_en || (press != 2'b00) || tick) begin
      auto_cnt <= '0;
    end else begin
      auto_cnt <= auto_cnt + 1'b1;
    end
  end

  assign step_up = press[0] || tick;
  assign step_dn = press[1];

  // Address register, stepped modulo 16; opposing requests cancel
  always_ff @(posedge clk) begin
    if (rst) begin
      addr <= 4'h0;
    end else if (step_up && !step_dn) begin
      addr <= addr + 4'h1;
    end else if (step_dn && !step_up) begin
      addr <= addr - 4'h1;
    end
  end

  assign ram.mem_choose = addr;

  // Word capture from the RAM port unless frozen
  always_ff @(posedge clk) begin
    if (rst) begin
      word <= 32'h0;
    end else if (!freeze) begin
      word <= ram.chosen_data;
    end
  end

  // Digit scan: each digit lit for SCAN_DIV cycles, index wraps 7 -> 0
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      digit    <= 3'd0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      digit    <= digit + 3'd1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  assign an     = ~(8'b1 << digit);
  assign nibble = word[{digit, 2'b00} +: 4];

  // Hex-to-seven-segment decode, active-low {g,f,e,d,c,b,a}
  always_comb begin
    seg = 7'b1111111;
    case (nibble)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'b1111111;
    endcase
  end

endmodule

// File: doc/ram_word_display.md
Name: ram_word_display

Overview:
- Debug viewer downstream of the data RAM's second read port.
- Drives the 4-bit word-select address into the RAM's chosen-word port, captures the returned 32-bit word, and shows it as 8 hex digits on a multiplexed active-low seven-segment display.
- The address is stepped by two debounced push-buttons, or advances automatically at a fixed rate.

Parameters:
- SCAN_DIV, 100000: clock cycles each digit stays lit (must be ≥2).
- DEB_CYCLES, 200000: consecutive stable cycles needed before a button level is accepted (must be ≥1).
- AUTO_DIV, 50000000: clock cycles between automatic address advances (must be ≥2).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  synchronous reset, active-high.
- btn_inc  input  1  raw push-button, asynchronous, bouncy; a press advances the address.
- btn_dec  input  1  raw push-button, asynchronous, bouncy; a press decrements the address.
- auto_en  input  1  high enables automatic address advance.
- freeze  input  1  high holds the captured word.
- chosen_data  input  32  word returned by the RAM for mem_choose (combinational read).
- mem_choose  output  4  word select to the RAM; also the current address.
- an  output  8  digit enables, active-low, one-hot-low.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high, sampled only on the clk rising edge, and has priority over all other activity.
- Reset values: address 0, word register 0, digit index 0, scan divider 0, auto divider 0. Both sync chains, both debounced levels and both debounce counters are cleared to 0.
- Output values during and immediately after reset: mem_choose=4'h0, an=8'hFE, seg=7'b1000000 (glyph "0").
- Reset mid-operation: all state is discarded on the next edge. A button still held when reset releases must be released and pressed again before it produces an event.
- Button path (each button independently):
  - 2-FF synchroniser.
  - Debounce counter increments while the synced level differs from the debounced level, and clears when they match.
  - On reaching DEB_CYCLES, the debounced level flips and the counter clears.
  - Only a 0→1 flip produces a press event: a 1-cycle internal pulse.
  - Latency: with btn_inc held steady from the edge that first samples it high, the address changes on edge 2+DEB_CYCLES.
  - Bounces shorter than DEB_CYCLES produce no event.
  - Release produces no event. Holding the button produces exactly one event.
- Auto advance:
  - While auto_en=1, the auto divider counts 0..AUTO_DIV-1; the terminal count produces a tick and wraps to 0.
  - auto_en=0 holds the divider at 0.
  - Any press event (inc or dec) clears the divider.
- Address update, once per edge: delta = (inc_evt OR tick) − dec_evt.
  - Possible deltas are +1, −1 or 0. inc and dec in the same cycle give 0; dec and tick in the same cycle give 0.
  - Arithmetic is modulo 16: 15+1→0, 0−1→15.
  - mem_choose is the address register itself, so it is registered.
- Word capture:
  - When freeze=0, the word register loads chosen_data on every edge.
  - When mem_choose changes at edge N, the new word is held at edge N+1.
  - When freeze=1, the word register holds; address stepping still occurs.
- Digit scan:
  - The scan divider counts 0..SCAN_DIV-1. At the terminal count it wraps and the digit index increments 0..7, with 7 wrapping to 0.
  - an = ~(8'b1 << digit).
  - Digit i displays word[4i+3:4i] (digit 0 is the rightmost nibble).
  - an and seg are combinational decodes of registered state; exactly one an bit is low at all times.
- Hex decode table (seg, active-low, gfedcba):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110

Test Plan (SCAN_DIV=4, DEB_CYCLES=3, AUTO_DIV=10; chosen_data model = 32'h1000_0000 + mem_choose×32'h0101_0101):
- Reset check: assert rst for 2 cycles → mem_choose=0, an=8'hFE, seg=7'b1000000. One edge after release, word=32'h10000000, and digit 7 later shows seg=7'b1111001 ("1").
- Debounced increment: hold btn_inc high → mem_choose changes 0→1 exactly on edge 5 and stays 1 while held. A glitch of 2 cycles high → no change.
- Wrap-around: from address 15, one debounced btn_inc → 0. From 0, one debounced btn_dec → 15 (word 32'h1F0F0F0F after 1 edge).
- Simultaneous events: btn_inc and btn_dec debounced on the same edge → address unchanged. auto tick coinciding with a dec event → unchanged.
- Auto advance and freeze:
  - auto_en=1 from address 3 → address becomes 4 after 10 cycles, then 5 after 20 cycles.
  - With freeze=1 set at address 4, the word stays 32'h14040404 while mem_choose continues to 5.
- Scan order: word=32'h89ABCDEF → an sequence FE,FD,FB,…,7F, each held 4 cycles, with seg F,E,d,C,b,A,9,8 per the decode table; the sequence then wraps to FE.
